// File: rtl/l2norm_pkg.sv
// Shared types and elaboration helpers for the streaming L2-norm engine.
package l2norm_pkg;

  typedef enum logic [1:0] {ACCUM, SQRT, OUTPUT} state_t;

  function automatic int unsigned keep_w(input int unsigned lanes, input int unsigned elem_w);
    return lanes * elem_w / 8;
  endfunction

  function automatic int unsigned root_w(input int unsigned acc_w);
    return acc_w / 2;
  endfunction

  function automatic bit params_ok(input int unsigned lanes, input int unsigned elem_w,
                                   input int unsigned acc_w, input int unsigned out_w);
    return (lanes > 0) && (elem_w % 8 == 0) && (elem_w > 0) && (acc_w % 2 == 0) &&
           (acc_w >= 2 * elem_w + 2) && (out_w >= acc_w / 2) && (out_w % 8 == 0);
  endfunction

endpackage

// File: rtl/l2_norm_axis_stream_isqrt.sv
// Bit-serial restoring integer square root; the first result bit is resolved on the start edge,
// so done pulses exactly ACC_W/2 cycles after start.
module isqrt_seq
  import l2norm_pkg::*;
#(
  parameter int unsigned ACC_W = 48
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ACC_W-1:0]       radicand,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W/2-1:0]     root
);

  localparam int unsigned ROOT_W = root_w(ACC_W);
  localparam int unsigned REM_W  = ROOT_W + 2;
  localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

  logic [ACC_W-1:0]  x_q, x_cur, x_d;
  logic [REM_W-1:0]  rem_q, rem_cur, rem_d;
  logic [ROOT_W-1:0] root_q, root_cur, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic [REM_W+1:0]  rem2, trial;

  always_comb begin
    x_cur    = start ? radicand : x_q;
    rem_cur  = start ? '0 : rem_q;
    root_cur = start ? '0 : root_q;
    rem2     = {rem_cur, x_cur[ACC_W-1 -: 2]};
    trial    = {2'b00, root_cur, 2'b01};
    x_d      = {x_cur[ACC_W-3:0], 2'b00};
    if (rem2 >= trial) begin
      rem_d  = REM_W'(rem2 - trial);
      root_d = {root_cur[ROOT_W-2:0], 1'b1};
    end else begin
      rem_d  = rem2[REM_W-1:0];
      root_d = {root_cur[ROOT_W-2:0], 1'b0};
    end
    cnt_d = start ? CNT_W'(ROOT_W - 1) : cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start || busy_q) begin
        x_q    <= x_d;
        rem_q  <= rem_d;
        root_q <= root_d;
        cnt_q  <= cnt_d;
        busy_q <= (cnt_d != '0);
        done_q <= (cnt_d == '0);
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign root = root_q;

endmodule

// File: rtl/l2_norm_axis_stream.sv
// Streaming L2-norm: saturating sum of squares per tlast-delimited packet, then floor(sqrt)
// emitted as a single-beat result packet. One packet in flight.
module l2_norm_axis_stream
  import l2norm_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LANES*ELEM_W-1:0]   in_tdata,
  input  logic                      in_tvalid,
  input  logic [LANES*ELEM_W/8-1:0] in_tkeep,
  input  logic                      in_tlast,
  input  logic                      in_tuser,
  output logic                      in_tready,
  output logic [OUT_W-1:0]          out_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic                      out_tuser,
  output logic [OUT_W/8-1:0]        out_tkeep,
  output logic                      out_tlast
);

  localparam int unsigned KEEP_W = keep_w(LANES, ELEM_W);
  localparam int unsigned ROOT_W = root_w(ACC_W);
  localparam int unsigned KB     = ELEM_W / 8;
  localparam int unsigned SUM_W  = 2 * ELEM_W + $clog2(LANES) + 1;
  localparam int unsigned TOT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  if (!params_ok(LANES, ELEM_W, ACC_W, OUT_W) || KEEP_W != LANES * KB) begin : gen_param_check
    $error("l2_norm_axis_stream: illegal parameter combination");
  end

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q, acc_next;
  logic              sat_q, sat_next, sat_pkt_q, overflow;
  logic              in_tready_q, out_tvalid_q, out_tuser_q;
  logic [OUT_W-1:0]  out_tdata_q;
  logic [ELEM_W-1:0] elem, mag;
  logic [2*ELEM_W-1:0] sq;
  logic [SUM_W-1:0]  beat_sum;
  logic [TOT_W-1:0]  total;
  logic              accept, sqrt_start, sqrt_busy, sqrt_done;
  logic [ROOT_W-1:0] root;
  logic              unused_tuser;

  assign unused_tuser = in_tuser;
  assign accept       = in_tvalid & in_tready_q;
  assign sqrt_start   = accept & in_tlast;

  // Lanes with any cleared keep byte contribute nothing.
  always_comb begin
    beat_sum = '0;
    elem     = '0;
    mag      = '0;
    sq       = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      elem = in_tdata[i*ELEM_W +: ELEM_W];
      mag  = elem[ELEM_W-1] ? (~elem + 1'b1) : elem;
      sq   = (2*ELEM_W)'(mag) * (2*ELEM_W)'(mag);
      if (&in_tkeep[i*KB +: KB]) beat_sum = beat_sum + SUM_W'(sq);
    end
    total    = TOT_W'(acc_q) + TOT_W'(beat_sum);
    overflow = |total[TOT_W-1:ACC_W];
    acc_next = overflow ? '1 : total[ACC_W-1:0];
    sat_next = sat_q | overflow;
  end

  isqrt_seq #(
    .ACC_W(ACC_W)
  ) u_isqrt (
    .clock   (clock),
    .reset   (reset),
    .start   (sqrt_start),
    .radicand(acc_next),
    .busy    (sqrt_busy),
    .done    (sqrt_done),
    .root    (root)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      sat_pkt_q    <= 1'b0;
      in_tready_q  <= 1'b1;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tuser_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (in_tlast) begin
              acc_q       <= '0;
              sat_q       <= 1'b0;
              sat_pkt_q   <= sat_next;
              in_tready_q <= 1'b0;
              state_q     <= SQRT;
            end else begin
              acc_q <= acc_next;
              sat_q <= sat_next;
            end
          end
        end
        SQRT: begin
          if (sqrt_done) begin
            state_q      <= OUTPUT;
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= OUT_W'(root);
            out_tuser_q  <= sat_pkt_q;
          end
        end
        OUTPUT: begin
          if (out_tready) begin
            state_q      <= ACCUM;
            out_tvalid_q <= 1'b0;
            in_tready_q  <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_tready  = in_tready_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tuser  = out_tuser_q;
  assign out_tlast  = out_tvalid_q;
  assign out_tkeep  = '1;

endmodule

// File: tb/tb_l2_norm_axis_stream.sv
// Directed bench: default instance (ACC_W=48) and a narrow-accumulator instance (ACC_W=34)
// for saturation; sel routes the handshakes to one instance at a time.
module tb_l2_norm_axis_stream;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, sel, tvalid, tlast, otready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic        a_ready, a_valid, a_user, a_last, b_ready, b_valid, b_user, b_last;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_keep, b_keep;
  logic        ready, ovalid, ouser, olast;
  logic [31:0] odata;

  int nvec = 0;
  int nfail = 0;

  l2_norm_axis_stream dut_a (
    .clock(clock), .reset(reset), .in_tdata(tdata), .in_tvalid(tvalid & ~sel),
    .in_tkeep(tkeep), .in_tlast(tlast), .in_tuser(1'b1), .in_tready(a_ready),
    .out_tdata(a_data), .out_tvalid(a_valid), .out_tready(otready & ~sel),
    .out_tuser(a_user), .out_tkeep(a_keep), .out_tlast(a_last)
  );

  l2_norm_axis_stream #(.ACC_W(34)) dut_b (
    .clock(clock), .reset(reset), .in_tdata(tdata), .in_tvalid(tvalid & sel),
    .in_tkeep(tkeep), .in_tlast(tlast), .in_tuser(1'b0), .in_tready(b_ready),
    .out_tdata(b_data), .out_tvalid(b_valid), .out_tready(otready & sel),
    .out_tuser(b_user), .out_tkeep(b_keep), .out_tlast(b_last)
  );

  always_comb begin
    ready  = sel ? b_ready : a_ready;
    ovalid = sel ? b_valid : a_valid;
    odata  = sel ? b_data  : a_data;
    ouser  = sel ? b_user  : a_user;
    olast  = sel ? b_last  : a_last;
  end

  typedef struct {
    logic [63:0] b0;
    logic [7:0]  k0;
    logic [63:0] b1;
    logic [7:0]  k1;
    int          nbeats;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    int n = 0;
    tdata = data; tkeep = keep; tlast = last; tvalid = 1'b1;
    while (!ready && n < 100) begin step(); n++; end
    if (!ready) check("in_tready_timeout", 0, 1);
    step();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Returns latency in cycles counted from the accepting cycle of the tlast beat.
  task automatic wait_result(output int lat);
    int n = 1;
    while (!ovalid && n < 200) begin step(); n++; end
    if (!ovalid) check("out_tvalid_timeout", 0, 1);
    lat = n;
  endtask

  task automatic handshake();
    otready = 1'b1;
    step();
    otready = 1'b0;
    check("valid_drops_after_handshake", ovalid, 0);
    check("ready_after_handshake", ready, 1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    reset = 1'b1; sel = 1'b0; tvalid = 1'b0; tlast = 1'b0; otready = 1'b0;
    tdata = '0; tkeep = '0;

    vecs[0] = '{pack(3, 4, 0, 0), 8'hFF, '0, '0, 1, 5};
    vecs[1] = '{pack(1, 1, 1, 1), 8'hFF, pack(-1, -1, -1, -1), 8'hFF, 2, 2};
    vecs[2] = '{pack(12, 5, 0, 0), 8'hFF, '0, '0, 1, 13};
    vecs[3] = '{pack(3, 4, 100, -100), 8'h0F, '0, '0, 1, 5};
    vecs[4] = '{pack(7, 7, 7, 7), 8'h00, '0, '0, 1, 0};
    vecs[5] = '{pack(-32768, -32768, -32768, -32768), 8'hFF, '0, '0, 1, 65536};
    vecs[6] = '{pack(1000, 7, -2000, 9), 8'h33, '0, '0, 1, 2236};
    vecs[7] = '{pack(3, 4, 0, 0), 8'h0D, '0, '0, 1, 4};

    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_in_tready", a_ready, 1);
    check("reset_out_tvalid", a_valid, 0);
    check("reset_out_tdata", a_data, 0);
    check("reset_out_tuser", a_user, 0);
    check("out_tkeep_ones", a_keep, 4'hF);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].nbeats == 2) begin
        beat(vecs[i].b0, vecs[i].k0, 1'b0);
        beat(vecs[i].b1, vecs[i].k1, 1'b1);
      end else begin
        beat(vecs[i].b0, vecs[i].k0, 1'b1);
      end
      wait_result(lat);
      check($sformatf("vec%0d_data", i), odata, vecs[i].exp_data);
      check($sformatf("vec%0d_user", i), ouser, 0);
      check($sformatf("vec%0d_tlast", i), olast, 1);
      if (i == 0) check("latency_acc48", lat, 25);
      handshake();
    end

    // Backpressure: result must hold while out_tready stays low.
    beat(pack(6, 8, 0, 0), 8'hFF, 1'b1);
    wait_result(lat);
    held = odata;
    check("bp_initial_data", held, 10);
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_data_stable", odata, 10);
      check("bp_valid_held", ovalid, 1);
      check("bp_in_tready_low", ready, 0);
    end
    handshake();

    // Saturation on the 34-bit accumulator instance.
    sel = 1'b1;
    step();
    for (int b = 0; b < 5; b++)
      beat(pack(-32768, -32768, -32768, -32768), 8'hFF, b == 4);
    wait_result(lat);
    check("sat_data", odata, 131071);
    check("sat_user", ouser, 1);
    check("latency_acc34", lat, 18);
    handshake();
    beat(pack(3, 4, 0, 0), 8'hFF, 1'b1);
    wait_result(lat);
    check("post_sat_data", odata, 5);
    check("post_sat_user", ouser, 0);
    handshake();

    // Reset mid-SQRT discards the result.
    sel = 1'b0;
    step();
    beat(pack(3, 4, 0, 0), 8'hFF, 1'b1);
    repeat (5) step();
    check("pre_reset_busy_ready", ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_sqrt_reset_valid", ovalid, 0);
    check("mid_sqrt_reset_ready", ready, 1);
    repeat (30) step();
    check("no_stale_result", ovalid, 0);
    beat(pack(6, 8, 0, 0), 8'hFF, 1'b1);
    wait_result(lat);
    check("after_reset_data", odata, 10);
    check("after_reset_latency", lat, 25);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
